// File: rtl/complex_alu_pkg.sv
// Shared definitions for the complex matrix ALU and its per-column multiplier.
// Operand format : {imag[SIZE-1:CW], real[CW-1:0]}, both signed two's complement.
// Result format  : {imag[2*RW-1:RW], real[RW-1:0]}, both signed, sign-extended.
package complex_alu_pkg;

    localparam int unsigned SIZE = 16;
    localparam int unsigned CW   = SIZE / 2;      // operand component width
    localparam int unsigned RW   = 3 * SIZE / 2;  // result component width

    typedef struct packed {
        logic signed [CW-1:0] im;
        logic signed [CW-1:0] re;
    } cplx_t;

    typedef struct packed {
        logic signed [RW-1:0] im;
        logic signed [RW-1:0] re;
    } cplx_res_t;

    function automatic logic [SIZE-1:0] pack_cplx(input logic signed [CW-1:0] re,
                                                  input logic signed [CW-1:0] im);
        return {im, re};
    endfunction

    function automatic cplx_t unpack_cplx(input logic [SIZE-1:0] d);
        return cplx_t'(d);
    endfunction

    function automatic logic [3*SIZE-1:0] pack_cplx_res(input logic signed [RW-1:0] re,
                                                        input logic signed [RW-1:0] im);
        return {im, re};
    endfunction

    function automatic cplx_res_t unpack_cplx_res(input logic [3*SIZE-1:0] d);
        return cplx_res_t'(d);
    endfunction

endpackage

// File: rtl/cplx_fifo.sv
// Registered (non fall-through) FIFO used for each multiplier input channel.
// A pushed word becomes visible on rdata_o the cycle after it is written.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, wdata_i    write request and data (ignored while full)
//   pop_i              read request (ignored while empty)
//   rdata_o            head entry, valid while empty_o = 0
//   full_o, empty_o    occupancy flags, derived from registered count only
module cplx_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so non power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/complex_mul_axis.sv
// Pipelined signed complex multiplier with AXI-Stream style handshakes.
// Operands A and B are queued in per-channel FIFOs, paired in arrival order,
// then pass through S1 (operands), S2 (partial products), S3 (output register).
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_axis_a_*                        operand A channel {imag, real}, SIZE bits
//   s_axis_b_*                        operand B channel {imag, real}, SIZE bits
//   m_axis_dout_*                     product channel {imag, real}, 3*SIZE bits
// Requires SIZE even and >= 4, IN_DEPTH >= 1.
module complex_mul_axis #(
    parameter int unsigned SIZE     = complex_alu_pkg::SIZE,
    parameter int unsigned IN_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_axis_a_tvalid,
    output logic                s_axis_a_tready,
    input  logic [SIZE-1:0]     s_axis_a_tdata,
    input  logic                s_axis_b_tvalid,
    output logic                s_axis_b_tready,
    input  logic [SIZE-1:0]     s_axis_b_tdata,
    output logic                m_axis_dout_tvalid,
    input  logic                m_axis_dout_tready,
    output logic [3*SIZE-1:0]   m_axis_dout_tdata
);

    localparam int unsigned HW = SIZE / 2;      // operand component width
    localparam int unsigned OW = 3 * SIZE / 2;  // result component width

    logic              a_full, a_empty, b_full, b_empty;
    logic [SIZE-1:0]   a_head, b_head;
    logic              join_en;
    logic              s1_ld, s2_ld, s3_ld;

    logic              s1_valid_q, s1_valid_d;
    logic [SIZE-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic              s2_valid_q, s2_valid_d;
    logic [SIZE-1:0]   pp_rr_q, pp_rr_d, pp_ii_q, pp_ii_d;
    logic [SIZE-1:0]   pp_ri_q, pp_ri_d, pp_ir_q, pp_ir_d;
    logic              s3_valid_q, s3_valid_d;
    logic [3*SIZE-1:0] dout_q, dout_d;

    // Components sign-extended to SIZE bits so the low SIZE bits of an unsigned
    // product equal the signed product, which always fits in SIZE bits.
    logic [SIZE-1:0]   ar, ai, br, bi;
    logic [SIZE:0]     re_sum, im_sum;

    // Ready depends on occupancy only; a pop in the same cycle does not free a slot.
    assign s_axis_a_tready = rst_n & ~a_full;
    assign s_axis_b_tready = rst_n & ~b_full;

    cplx_fifo #(
        .Width (SIZE),
        .Depth (IN_DEPTH)
    ) u_fifo_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (s_axis_a_tvalid & s_axis_a_tready),
        .wdata_i (s_axis_a_tdata),
        .pop_i   (join_en),
        .rdata_o (a_head),
        .full_o  (a_full),
        .empty_o (a_empty)
    );

    cplx_fifo #(
        .Width (SIZE),
        .Depth (IN_DEPTH)
    ) u_fifo_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (s_axis_b_tvalid & s_axis_b_tready),
        .wdata_i (s_axis_b_tdata),
        .pop_i   (join_en),
        .rdata_o (b_head),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    // Each stage may load when empty or when it drains this cycle; bubbles collapse.
    always_comb begin
        s3_ld   = ~s3_valid_q | m_axis_dout_tready;
        s2_ld   = ~s2_valid_q | s3_ld;
        s1_ld   = ~s1_valid_q | s2_ld;
        join_en = ~a_empty & ~b_empty & s1_ld;
    end

    always_comb begin
        ar = {{HW{s1_a_q[HW-1]}},   s1_a_q[HW-1:0]};
        ai = {{HW{s1_a_q[SIZE-1]}}, s1_a_q[SIZE-1:HW]};
        br = {{HW{s1_b_q[HW-1]}},   s1_b_q[HW-1:0]};
        bi = {{HW{s1_b_q[SIZE-1]}}, s1_b_q[SIZE-1:HW]};
        re_sum = {pp_rr_q[SIZE-1], pp_rr_q} - {pp_ii_q[SIZE-1], pp_ii_q};
        im_sum = {pp_ri_q[SIZE-1], pp_ri_q} + {pp_ir_q[SIZE-1], pp_ir_q};
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        pp_rr_d    = pp_rr_q;
        pp_ii_d    = pp_ii_q;
        pp_ri_d    = pp_ri_q;
        pp_ir_d    = pp_ir_q;
        s3_valid_d = s3_valid_q;
        dout_d     = dout_q;

        if (s1_ld) begin
            s1_valid_d = join_en;
            if (join_en) begin
                s1_a_d = a_head;
                s1_b_d = b_head;
            end
        end

        if (s2_ld) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                pp_rr_d = ar * br;
                pp_ii_d = ai * bi;
                pp_ri_d = ar * bi;
                pp_ir_d = ai * br;
            end
        end

        // Data only changes on a real load so tdata keeps its last value when idle.
        if (s3_ld) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                dout_d = {{(OW-SIZE-1){im_sum[SIZE]}}, im_sum,
                          {(OW-SIZE-1){re_sum[SIZE]}}, re_sum};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            pp_rr_q    <= '0;
            pp_ii_q    <= '0;
            pp_ri_q    <= '0;
            pp_ir_q    <= '0;
            s3_valid_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            pp_rr_q    <= pp_rr_d;
            pp_ii_q    <= pp_ii_d;
            pp_ri_q    <= pp_ri_d;
            pp_ir_q    <= pp_ir_d;
            s3_valid_q <= s3_valid_d;
            dout_q     <= dout_d;
        end
    end

    assign m_axis_dout_tvalid = s3_valid_q;
    assign m_axis_dout_tdata  = dout_q;

endmodule

// File: tb/tb_complex_mul_axis.sv
// Scoreboard bench for complex_mul_axis: drivers record accepted beats into a
// pairing model that queues expected products; a monitor checks each output.
module tb_complex_mul_axis;
    import complex_alu_pkg::*;

    localparam int unsigned IN_DEPTH = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                s_axis_a_tvalid, s_axis_a_tready;
    logic [SIZE-1:0]     s_axis_a_tdata;
    logic                s_axis_b_tvalid, s_axis_b_tready;
    logic [SIZE-1:0]     s_axis_b_tdata;
    logic                m_axis_dout_tvalid, m_axis_dout_tready;
    logic [3*SIZE-1:0]   m_axis_dout_tdata;

    complex_mul_axis #(
        .SIZE     (SIZE),
        .IN_DEPTH (IN_DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axis_a_tvalid    (s_axis_a_tvalid),
        .s_axis_a_tready    (s_axis_a_tready),
        .s_axis_a_tdata     (s_axis_a_tdata),
        .s_axis_b_tvalid    (s_axis_b_tvalid),
        .s_axis_b_tready    (s_axis_b_tready),
        .s_axis_b_tdata     (s_axis_b_tdata),
        .m_axis_dout_tvalid (m_axis_dout_tvalid),
        .m_axis_dout_tready (m_axis_dout_tready),
        .m_axis_dout_tdata  (m_axis_dout_tdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [SIZE-1:0] d;
        int              e;   // clock edge at which the beat was accepted
    } beat_t;
    typedef struct {
        logic [3*SIZE-1:0] d;
        int                e; // edge after which the product must be presented
    } exp_t;

    beat_t a_sent[$];
    beat_t b_sent[$];
    exp_t  exp_q[$];

    function automatic logic [3*SIZE-1:0] ref_mul(input logic [SIZE-1:0] a,
                                                  input logic [SIZE-1:0] b);
        cplx_t ca, cb;
        int re, im;
        ca = unpack_cplx(a);
        cb = unpack_cplx(b);
        re = int'(ca.re) * int'(cb.re) - int'(ca.im) * int'(cb.im);
        im = int'(ca.re) * int'(cb.im) + int'(ca.im) * int'(cb.re);
        return pack_cplx_res(RW'(re), RW'(im));
    endfunction

    function automatic void pair_up();
        beat_t a, b;
        exp_t  x;
        while (a_sent.size() > 0 && b_sent.size() > 0) begin
            a = a_sent.pop_front();
            b = b_sent.pop_front();
            x.d = ref_mul(a.d, b.d);
            x.e = ((a.e > b.e) ? a.e : b.e) + 3;
            exp_q.push_back(x);
        end
    endfunction

    // ---------------- monitor ----------------
    bit                lat_check = 1'b0;
    int                out_count = 0;
    int                last_out_cyc = 0;
    logic [3*SIZE-1:0] last_dout = '0;
    bit                stalled = 1'b0;
    logic [3*SIZE-1:0] held = '0;

    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) check("stall_hold", {m_axis_dout_tvalid, m_axis_dout_tdata}, {1'b1, held});
            stalled = 1'b0;
            if (m_axis_dout_tvalid) begin
                if (m_axis_dout_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0h want none", m_axis_dout_tdata);
                    end else begin
                        x = exp_q.pop_front();
                        check("product", m_axis_dout_tdata, x.d);
                        if (lat_check) check("latency_edge", cyc, x.e);
                    end
                    out_count++;
                    last_out_cyc = cyc;
                    last_dout    = m_axis_dout_tdata;
                end else begin
                    stalled = 1'b1;
                    held    = m_axis_dout_tdata;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    logic [SIZE-1:0] a_list[$];
    logic [SIZE-1:0] b_list[$];

    // Called just after a rising edge. Offers a_list/b_list on both channels; a
    // raised valid is held until accepted. Returns number of beats accepted.
    task automatic drive(input int b_delay, input int gap_pct, input int budget,
                         input bit rand_rdy, output int na, output int nb);
        int ia = 0;
        int ib = 0;
        int t  = 0;
        bit a_pend = 1'b0;
        bit b_pend = 1'b0;
        while ((ia < a_list.size() || ib < b_list.size()) && t < budget) begin
            if (rand_rdy) m_axis_dout_tready = ($urandom_range(3) != 0);
            if (!a_pend) s_axis_a_tvalid = (ia < a_list.size()) && (int'($urandom_range(99)) >= gap_pct);
            if (ia < a_list.size()) s_axis_a_tdata = a_list[ia];
            if (!b_pend) s_axis_b_tvalid = (ib < b_list.size()) && (t >= b_delay)
                                           && (int'($urandom_range(99)) >= gap_pct);
            if (ib < b_list.size()) s_axis_b_tdata = b_list[ib];
            @(negedge clk);
            if (s_axis_a_tvalid && s_axis_a_tready) begin
                a_sent.push_back('{s_axis_a_tdata, cyc + 1});
                ia++;
                a_pend = 1'b0;
            end else begin
                a_pend = s_axis_a_tvalid;
            end
            if (s_axis_b_tvalid && s_axis_b_tready) begin
                b_sent.push_back('{s_axis_b_tdata, cyc + 1});
                ib++;
                b_pend = 1'b0;
            end else begin
                b_pend = s_axis_b_tvalid;
            end
            pair_up();
            @(posedge clk);
            #1;
            t++;
        end
        s_axis_a_tvalid = 1'b0;
        s_axis_b_tvalid = 1'b0;
        na = ia;
        nb = ib;
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (exp_q.size() > 0 && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic wait_out(input int n0, input string name);
        int t = 0;
        while (out_count == n0 && t < 20) begin
            @(posedge clk);
            #2;
            t++;
        end
        check(name, out_count > n0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int na, nb, n0, c0;

        rst_n              = 1'b0;
        s_axis_a_tvalid    = 1'b0;
        s_axis_b_tvalid    = 1'b0;
        s_axis_a_tdata     = '0;
        s_axis_b_tdata     = '0;
        m_axis_dout_tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", m_axis_dout_tvalid, 0);
        check("rst_tdata", m_axis_dout_tdata, 0);
        check("rst_a_tready", s_axis_a_tready, 0);
        check("rst_b_tready", s_axis_b_tready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_a_tready", s_axis_a_tready, 1);
        check("post_rst_b_tready", s_axis_b_tready, 1);

        // Single pair: (2+4j)(7+4j) = -2+36j
        lat_check = 1'b1;
        a_list = '{16'h0402};
        b_list = '{16'h0407};
        n0 = out_count;
        drive(0, 0, 20, 1'b0, na, nb);
        wait_out(n0, "single_out");
        check("single_value", last_dout, 48'h000024_FFFFFE);
        check("single_one_cycle", m_axis_dout_tvalid, 0);

        // Extremes
        a_list = '{16'h8080};
        b_list = '{16'h8080};
        n0 = out_count;
        drive(0, 0, 20, 1'b0, na, nb);
        wait_out(n0, "ext1_out");
        check("ext1_value", last_dout, 48'h008000_000000);
        a_list = '{16'h7F7F};
        b_list = '{16'h8080};
        drive(0, 0, 20, 1'b0, na, nb);
        wait_drain(20);

        // Streaming: back-to-back pairs, each must meet latency 3 exactly
        a_list.delete();
        b_list.delete();
        for (int i = 0; i < 9; i++) begin
            a_list.push_back(SIZE'($urandom));
            b_list.push_back(SIZE'($urandom));
        end
        drive(0, 0, 9, 1'b0, na, nb);
        check("stream_a_accepted", na, 9);
        check("stream_b_accepted", nb, 9);
        wait_drain(20);

        // Backpressure: capacity is 3 in flight plus IN_DEPTH per FIFO
        lat_check = 1'b0;
        m_axis_dout_tready = 1'b0;
        a_list.delete();
        b_list.delete();
        for (int i = 0; i < 8; i++) begin
            a_list.push_back(SIZE'($urandom));
            b_list.push_back(SIZE'($urandom));
        end
        drive(0, 0, 12, 1'b0, na, nb);
        check("bp_a_accepted", na, 5);
        check("bp_b_accepted", nb, 5);
        check("bp_a_tready", s_axis_a_tready, 0);
        check("bp_b_tready", s_axis_b_tready, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        n0 = out_count;
        c0 = cyc;
        m_axis_dout_tready = 1'b1;
        wait_drain(30);
        check("bp_count", out_count - n0, 5);
        check("bp_consecutive", last_out_cyc, c0 + 4);

        // Skewed channels
        lat_check = 1'b1;
        a_list = '{16'h0102, 16'hFE03};
        b_list.delete();
        n0 = out_count;
        drive(0, 0, 10, 1'b0, na, nb);
        check("skew_a_tready", s_axis_a_tready, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("skew_no_output", out_count, n0);
        check("skew_a_tready_held", s_axis_a_tready, 0);
        a_list.delete();
        b_list = '{16'h0305, 16'h7F80};
        drive(0, 0, 10, 1'b0, na, nb);
        wait_drain(20);
        check("skew_count", out_count - n0, 2);

        // Random traffic with random backpressure
        lat_check = 1'b0;
        a_list.delete();
        b_list.delete();
        for (int i = 0; i < 40; i++) begin
            a_list.push_back(SIZE'($urandom));
            b_list.push_back(SIZE'($urandom));
        end
        drive(0, 30, 400, 1'b1, na, nb);
        check("rand_a_accepted", na, 40);
        check("rand_b_accepted", nb, 40);
        m_axis_dout_tready = 1'b1;
        wait_drain(40);

        // Reset with three products in flight
        m_axis_dout_tready = 1'b0;
        a_list.delete();
        b_list.delete();
        for (int i = 0; i < 3; i++) begin
            a_list.push_back(SIZE'($urandom));
            b_list.push_back(SIZE'($urandom));
        end
        drive(0, 0, 10, 1'b0, na, nb);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", m_axis_dout_tvalid, 0);
        check("mid_rst_tdata", m_axis_dout_tdata, 0);
        check("mid_rst_a_tready", s_axis_a_tready, 0);
        a_sent.delete();
        b_sent.delete();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_axis_dout_tready = 1'b1;
        n0 = out_count;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("no_stale_output", out_count, n0);
        lat_check = 1'b1;
        a_list = '{16'hFD06};
        b_list = '{16'h0AF9};
        drive(0, 0, 10, 1'b0, na, nb);
        wait_drain(20);
        check("post_rst_count", out_count - n0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
